// File: rtl/ipg_tx_inserter_if.sv
// IPG message chunk handshake between the message source and the TX inserter.
// The source drives chunk/valid/last; the inserter answers with a combinational ready.
interface ipg_tx_inserter_if;
    logic [55:0] msg_data;
    logic        msg_valid;
    logic        msg_last;
    logic        msg_ready;

    modport master (
        output msg_data,
        output msg_valid,
        output msg_last,
        input  msg_ready
    );

    modport slave (
        input  msg_data,
        input  msg_valid,
        input  msg_last,
        output msg_ready
    );
endinterface

// File: rtl/ipg_tx_inserter.sv
// 64b/66b TX-path IPG inserter: swaps idle blocks for IPG message blocks, pre-empts at frame
// starts when a message is overdue or mid-transfer, and drains the buffered frame by dropping idles.
module ipg_tx_inserter #(
    parameter int unsigned NET_DEPTH      = 8,
    parameter int unsigned MAX_WAIT       = 16,
    parameter logic [7:0]  IPG_BLOCK_TYPE = 8'h77
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              in_hdr,
    input  logic [63:0]             in_data,
    ipg_tx_inserter_if.slave        msg,
    output logic [1:0]              out_hdr,
    output logic [63:0]             out_data,
    output logic [1:0]              tuser,
    output logic                    msg_sent,
    output logic                    overflow
);

    localparam int unsigned PtrW  = (NET_DEPTH > 1) ? $clog2(NET_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [CntW-1:0]  FullCount = CntW'(NET_DEPTH);
    localparam logic [WaitW-1:0] WaitMax   = WaitW'(MAX_WAIT);
    localparam logic [1:0]       HdrCtrl   = 2'b01;
    localparam logic [63:0]      IdleData  = 64'h1e;
    localparam logic [1:0]       TuNet     = 2'b00;
    localparam logic [1:0]       TuIpg     = 2'b01;
    localparam logic [1:0]       TuFill    = 2'b10;

    typedef enum logic [1:0] {
        StPass,
        StPreempt,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [65:0]       mem_q [NET_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic              in_msg_q, in_msg_d;
    logic [1:0]        out_hdr_q, out_hdr_d;
    logic [63:0]       out_data_q, out_data_d;
    logic [1:0]        tuser_q, tuser_d;
    logic              msg_sent_q, msg_sent_d;
    logic              overflow_q, overflow_d;

    logic in_idle;
    logic in_start;
    logic preempt_cond;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic push_ok;
    logic fifo_pop;
    logic ready;
    logic msg_pop;

    always_comb begin
        in_idle  = (in_hdr == HdrCtrl) && (in_data[7:0] == 8'h1e) && (in_data[63:8] == '0);
        in_start = (in_hdr == HdrCtrl) && ((in_data[7:0] == 8'h78) || (in_data[7:0] == 8'h33));
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FullCount);
        // wait_cnt saturates at MAX_WAIT, so equality marks an overdue message
        preempt_cond = in_start && msg.msg_valid && (in_msg_q || (wait_cnt_q == WaitMax));
    end

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        fifo_pop   = 1'b0;
        ready      = 1'b0;
        out_hdr_d  = in_hdr;
        out_data_d = in_data;
        tuser_d    = TuNet;

        unique case (state_q)
            StPass: begin
                ready = in_idle || preempt_cond;
                if (preempt_cond) begin
                    push    = 1'b1;
                    state_d = msg.msg_last ? StDrain : StPreempt;
                end
            end
            StPreempt: begin
                ready = 1'b1;
                push  = 1'b1;
                if (msg.msg_valid) begin
                    if (msg.msg_last) begin
                        state_d = StDrain;
                    end
                end else begin
                    out_hdr_d  = HdrCtrl;
                    out_data_d = IdleData;
                    tuser_d    = TuFill;
                end
            end
            StDrain: begin
                if (!fifo_empty) begin
                    push                   = !in_idle;
                    fifo_pop               = 1'b1;
                    {out_hdr_d, out_data_d} = mem_q[rd_ptr_q];
                    if ((count_q == CntW'(1)) && in_idle) begin
                        state_d = StPass;
                    end
                end else begin
                    // Unreachable in normal flow; fall back to pass-through to stay in order
                    state_d = StPass;
                end
            end
            default: state_d = StPass;
        endcase

        ready   = ready && rst_n;
        msg_pop = ready && msg.msg_valid;
        if (msg_pop) begin
            out_hdr_d  = HdrCtrl;
            out_data_d = {msg.msg_data, IPG_BLOCK_TYPE};
            tuser_d    = TuIpg;
        end
    end

    always_comb begin
        push_ok    = push && (!fifo_full || fifo_pop);
        overflow_d = overflow_q || (push && fifo_full && !fifo_pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = fifo_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !fifo_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && fifo_pop) begin
            count_d = count_q - CntW'(1);
        end

        wait_cnt_d = wait_cnt_q;
        if (msg_pop) begin
            wait_cnt_d = '0;
        end else if (msg.msg_valid && !in_msg_q && (wait_cnt_q != WaitMax)) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end

        in_msg_d   = msg_pop ? !msg.msg_last : in_msg_q;
        msg_sent_d = msg_pop && msg.msg_last;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {in_hdr, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StPass;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            in_msg_q   <= 1'b0;
            out_hdr_q  <= HdrCtrl;
            out_data_q <= IdleData;
            tuser_q    <= TuNet;
            msg_sent_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            in_msg_q   <= in_msg_d;
            out_hdr_q  <= out_hdr_d;
            out_data_q <= out_data_d;
            tuser_q    <= tuser_d;
            msg_sent_q <= msg_sent_d;
            overflow_q <= overflow_d;
        end
    end

    assign msg.msg_ready = ready;
    assign out_hdr       = out_hdr_q;
    assign out_data      = out_data_q;
    assign tuser         = tuser_q;
    assign msg_sent      = msg_sent_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/ipg_tx_inserter.md
Name: ipg_tx_inserter

Overview:
- Parametrised successor to the IPG transmit mux on the 64b/66b TX path.
- Sits between the PCS encoder output and the gearbox.
- Opportunistically replaces pure idle control blocks with IPG message blocks.
- When a message has waited too long, or is already mid-transfer, it pre-empts at a frame start. Network blocks are buffered meanwhile, and the backlog is recovered by deleting idles.

Parameters:
- NET_DEPTH, 8: network block FIFO depth; power of 2, at least 2.
- MAX_WAIT, 16: cycles a pending message start may wait for idles before pre-emption is allowed; 0 means pre-empt at the first frame start.
- IPG_BLOCK_TYPE, 8'h77: block type byte marking an IPG message block.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_hdr  in  2  encoded sync header, one block per cycle, always valid
- in_data  in  64  encoded block payload, [7:0] = block type
- msg_data  in  56  IPG message chunk
- msg_valid  in  1  chunk available
- msg_last  in  1  chunk is the final chunk of a message
- msg_ready  out  1  chunk consumed this cycle (combinational)
- out_hdr  out  2  registered output sync header
- out_data  out  64  registered output block
- tuser  out  2  00 network block, 01 IPG block, 10 inserted idle filler
- msg_sent  out  1  one-cycle pulse, registered with the block carrying msg_last
- overflow  out  1  sticky; set on a push to a full network FIFO

Behaviour:
- Reset values: out_hdr=2'b01, out_data=64'h1e, tuser=00, msg_sent=0, overflow=0, state=PASS, FIFO empty, wait_cnt=0, in_msg=0.
- Latency: output is registered; an input block passed through appears one cycle later.
- Idle block: in_hdr==01 && in_data[7:0]==8'h1e && in_data[63:8]==0.
- Start block: in_hdr==01 && type is 8'h78 or 8'h33.
- IPG block format: hdr=01, data={msg_data, IPG_BLOCK_TYPE}.
- wait_cnt: increments, saturating at MAX_WAIT, while msg_valid && !in_msg and no chunk is popped; clears on any pop.
- in_msg: set on a pop with !msg_last; cleared on a pop with msg_last.
- preempt_cond = start block && msg_valid && (in_msg || wait_cnt>=MAX_WAIT).

PASS state (FIFO empty):
- Idle input && msg_valid: output the IPG block, pop.
- preempt_cond: push the input block into the FIFO, output the IPG block, pop, go PREEMPT. If that chunk is msg_last, go DRAIN instead.
- Otherwise: output the input block, tuser=00.
- in_msg with an idle input but msg_valid low: output the idle as-is, tuser=00.

PREEMPT state:
- Every input block is pushed into the FIFO.
- msg_valid high: output the IPG block, pop. A pop with msg_last goes to DRAIN.
- msg_valid low: output idle 64'h1e with tuser=10.

DRAIN state:
- Output the FIFO head with tuser=00.
- An incoming idle block is discarded, not pushed.
- Any other incoming block is pushed.
- msg_ready=0 in DRAIN.
- Pop-and-empty while the current input is an idle: go to PASS the next cycle.

Other rules:
- msg_ready = (PASS && ((idle input && !preempt_cond) || preempt_cond)) || PREEMPT. It is 0 while rst_n is low.
- Full FIFO push: the block is dropped and overflow is set. The state machine proceeds unchanged.
- Simultaneous push and pop: count is unchanged; a push to a full FIFO is legal when a pop occurs in the same cycle.
- Pointer wrap: modulo NET_DEPTH; count width is clog2(NET_DEPTH)+1.
- Reset mid-operation: FIFO contents are discarded and the partial message is abandoned. The upstream must restart the message.

Test Plan:
- Reset check: rst_n low mid-stream -> out=01/64'h1e, tuser=00, msg_ready=0, overflow=0; then an idle-only stream passes unchanged with 1-cycle latency.
- Idle insertion: 4 idles in; 2-chunk message (56'hA1..., 56'hB2..., last on 2nd) -> outputs 2 blocks with data[7:0]=8'h77, tuser=01, msg_sent pulse on the 2nd block, then 2 idles.
- Pre-empt: MAX_WAIT=0, back-to-back frames (8'h78 start, 6 data blocks, 8'h87 term, 1 idle), 3-chunk message arriving with the frame start -> 3 IPG blocks, then the frame intact and in order. The FIFO drains by discarding the following idles.
- Stall mid-message: msg_valid drops for 2 cycles in PREEMPT -> two tuser=10 idles inserted; the buffered frame is unchanged afterwards.
- Overflow: NET_DEPTH=4, 6-block pre-emption with no idles arriving -> overflow=1 on the 5th push; blocks 5 and 6 are dropped; the sticky flag stays set until reset.
- Mid-frame protection: message valid with wait_cnt<MAX_WAIT during a frame body -> no IPG block is ever emitted between the start and term blocks.
